// File: rtl/m68k_dma_arbiter_pkg.sv
// Shared types for the 68000 DMA bus arbiter: FSM state encoding and a
// lowest-index-first priority encoder usable by any requester count up to PRIO_MAX_W.
package m68k_dma_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    REQ  = 2'b01,
    ACK  = 2'b10
  } state_t;

  localparam int PRIO_MAX_W = 32;
  localparam int PRIO_IDX_W = 5;

  typedef struct packed {
    logic                  vld;
    logic [PRIO_IDX_W-1:0] idx;
  } prio_t;

  // Bit 0 has highest priority: scanning downward leaves the lowest set index.
  function automatic prio_t prio_lowest(input logic [PRIO_MAX_W-1:0] vec);
    prio_t r;
    r.vld = |vec;
    r.idx = '0;
    for (int i = PRIO_MAX_W - 1; i >= 0; i--) begin
      if (vec[i]) r.idx = PRIO_IDX_W'(i);
    end
    return r;
  endfunction

endpackage

// File: rtl/m68k_dma_arbiter_if.sv
// Arbiter-side bundle: 68000 BRn/BGn/BGACKn wires plus per-device request/grant.
// master = arbiter view, slave = CPU/device environment view.
interface m68k_dma_arbiter_if #(
  parameter int BW = 1
);
  logic          cpu_BRn;
  logic          cpu_BGACKn;
  logic          cpu_BGn;
  logic [BW-1:0] dev_br;
  logic [BW-1:0] dev_bg;

  modport master (
    output cpu_BRn,
    output cpu_BGACKn,
    output dev_bg,
    input  cpu_BGn,
    input  dev_br
  );

  modport slave (
    input  cpu_BRn,
    input  cpu_BGACKn,
    input  dev_bg,
    output cpu_BGn,
    output dev_br
  );
endinterface

// File: rtl/m68k_dma_arbiter_prio_enc.sv
// Combinational fixed-priority encoder (bit 0 wins); zero latency, no flow control.
// BW is limited to PRIO_MAX_W requesters.
module m68k_prio_enc
  import m68k_dma_arbiter_pkg::*;
#(
  parameter int BW = 1,
  parameter int IW = (BW > 1) ? $clog2(BW) : 1
) (
  input  logic [BW-1:0] i_vec,
  output logic          o_vld,
  output logic [IW-1:0] o_idx
);
  prio_t w_res;

  assign w_res = prio_lowest(PRIO_MAX_W'(i_vec));
  assign o_vld = w_res.vld;
  assign o_idx = IW'(w_res.idx);
endmodule

// File: rtl/m68k_dma_arbiter.sv
// Turns level device requests into the 68000 BRn/BGn/BGACKn handshake and reports the owner.
// Outputs decode registered state only: BRn one edge after request, BGACKn on the BGn-sampling edge.
module m68k_dma_arbiter
  import m68k_dma_arbiter_pkg::*;
#(
  parameter int BW = 1
) (
  input  logic                clk,
  input  logic                rst,
  m68k_dma_arbiter_if.master  bus
);
  localparam int IW = (BW > 1) ? $clog2(BW) : 1;

  state_t        r_state;
  state_t        w_next;
  logic [IW-1:0] r_owner;
  logic          w_req_vld;
  logic [IW-1:0] w_req_idx;
  logic [BW-1:0] w_own_oh;
  logic          w_own_req;
  logic          w_brn;
  logic          w_bgackn;
  logic [BW-1:0] w_bg;

  m68k_prio_enc #(
    .BW (BW),
    .IW (IW)
  ) u_prio_enc (
    .i_vec (bus.dev_br),
    .o_vld (w_req_vld),
    .o_idx (w_req_idx)
  );

  assign w_own_oh  = BW'(1) << r_owner;
  assign w_own_req = |(bus.dev_br & w_own_oh);

  // Owner is latched only when leaving IDLE, so later requests cannot steal the bus.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_owner <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == IDLE && w_req_vld) r_owner <= w_req_idx;
    end
  end

  always_comb begin
    w_next = IDLE;
    case (r_state)
      IDLE:    w_next = w_req_vld ? REQ : IDLE;
      REQ: begin
        if (!w_own_req)        w_next = IDLE;
        else if (!bus.cpu_BGn) w_next = ACK;
        else                   w_next = REQ;
      end
      ACK:     w_next = w_own_req ? ACK : IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    w_brn    = 1'b1;
    w_bgackn = 1'b1;
    w_bg     = '0;
    case (r_state)
      REQ: w_brn = 1'b0;
      ACK: begin
        w_bgackn = 1'b0;
        w_bg     = w_own_oh;
      end
      default: ;
    endcase
  end

  assign bus.cpu_BRn    = w_brn;
  assign bus.cpu_BGACKn = w_bgackn;
  assign bus.dev_bg     = w_bg;
endmodule

// File: tb/tb_m68k_dma_arbiter.sv
// Directed bench for m68k_dma_arbiter (BW=2): per-cycle compare against a behavioural
// model of the bus-ownership rules, plus hand-computed literal checks at key points.
module tb_m68k_dma_arbiter;
  localparam int BW = 2;

  logic clk;
  logic rst;
  int   n_vec;
  int   n_err;

  m68k_dma_arbiter_if #(.BW(BW)) bus ();

  m68k_dma_arbiter #(.BW(BW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: who (if anyone) is asking the CPU, who holds the bus, and for which device.
  bit m_asking;
  bit m_holding;
  int m_dev;

  function automatic int lowest_req(input logic [BW-1:0] v);
    for (int i = 0; i < BW; i++) if (v[i]) return i;
    return 0;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_asking  <= 1'b0;
      m_holding <= 1'b0;
      m_dev     <= 0;
    end else if (m_holding) begin
      if (!bus.dev_br[m_dev]) m_holding <= 1'b0;
    end else if (m_asking) begin
      if (!bus.dev_br[m_dev]) m_asking <= 1'b0;
      else if (!bus.cpu_BGn) begin
        m_asking  <= 1'b0;
        m_holding <= 1'b1;
      end
    end else if (bus.dev_br != '0) begin
      m_dev    <= lowest_req(bus.dev_br);
      m_asking <= 1'b1;
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    logic [BW-1:0] e_bg;
    e_bg = m_holding ? BW'(1 << m_dev) : '0;
    chk("model_BRn", int'(bus.cpu_BRn), int'(!m_asking));
    chk("model_BGACKn", int'(bus.cpu_BGACKn), int'(!m_holding));
    chk("model_dev_bg", int'(bus.dev_bg), int'(e_bg));
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic chk3(input string name, input int brn, input int bgackn, input int bg);
    chk({name, "_BRn"}, int'(bus.cpu_BRn), brn);
    chk({name, "_BGACKn"}, int'(bus.cpu_BGACKn), bgackn);
    chk({name, "_dev_bg"}, int'(bus.dev_bg), bg);
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst = 1'b1;
    bus.cpu_BGn = 1'b1;
    bus.dev_br  = 2'b01;

    // Reset held with a live request: nothing may assert.
    repeat (3) begin
      step();
      chk3("reset", 1, 1, 0);
    end
    rst = 1'b0;
    step();
    chk3("req_after_reset", 0, 1, 0);

    // Full handshake on device 0, grant three cycles after BRn.
    step();
    step();
    bus.cpu_BGn = 1'b0;
    step();
    chk3("grant", 1, 0, 1);
    bus.cpu_BGn = 1'b1;
    repeat (10) step();
    chk3("hold", 1, 0, 1);
    bus.dev_br = 2'b00;
    step();
    chk3("release", 1, 1, 0);
    step();

    // Abort before grant.
    bus.dev_br = 2'b01;
    step();
    chk3("abort_req", 0, 1, 0);
    step();
    bus.dev_br = 2'b00;
    step();
    chk3("abort_idle", 1, 1, 0);
    step();

    // Simultaneous requests: device 0 wins, device 1 waits for a fresh handshake.
    bus.dev_br = 2'b11;
    step();
    chk3("prio_req", 0, 1, 0);
    bus.cpu_BGn = 1'b0;
    step();
    chk3("prio_grant0", 1, 0, 1);
    bus.cpu_BGn = 1'b1;
    step();
    bus.dev_br = 2'b10;
    step();
    chk3("prio_gap", 1, 1, 0);
    step();
    chk3("prio_rereq", 0, 1, 0);
    bus.cpu_BGn = 1'b0;
    step();
    chk3("prio_grant1", 1, 0, 2);
    bus.cpu_BGn = 1'b1;
    bus.dev_br = 2'b00;
    step();
    step();

    // Spurious grant while idle.
    bus.cpu_BGn = 1'b0;
    step();
    step();
    chk3("spurious", 1, 1, 0);
    bus.cpu_BGn = 1'b1;

    // Owner drops in REQ while device 1 asks: back to IDLE, then device 1 re-arbitrates.
    bus.dev_br = 2'b01;
    step();
    bus.dev_br = 2'b10;
    step();
    chk3("swap_idle", 1, 1, 0);
    step();
    bus.cpu_BGn = 1'b0;
    step();
    chk3("swap_grant1", 1, 0, 2);

    // Asynchronous reset while the bus is held.
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk3("async_rst", 1, 1, 0);
    bus.cpu_BGn = 1'b1;
    bus.dev_br  = 2'b00;
    step();
    rst = 1'b0;
    repeat (3) step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
